// File: rtl/mux_operand_skid_reg.sv
// Registered operand/select stage ahead of the 2:1 operand/PC-select mux.
// One-entry skid buffer keeps in_ready_o registered at full throughput.
//
// state | meaning
// EMPTY | main and skid empty, accepting
// BUSY  | main holds output bundle, skid empty, accepting
// FULL  | main and skid both hold bundles, not accepting
module mux_operand_skid_reg #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [size-1:0] data0_i,
    input  logic [size-1:0] data1_i,
    input  logic            select_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [size-1:0] data0_o,
    output logic [size-1:0] data1_o,
    output logic            select_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [size-1:0]   r_main_d0;
    logic [size-1:0]   r_main_d1;
    logic              r_main_sel;
    logic [size-1:0]   r_skid_d0;
    logic [size-1:0]   r_skid_d1;
    logic              r_skid_sel;

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = in_valid_i & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_d0   <= '0;
            r_main_d1   <= '0;
            r_main_sel  <= 1'b0;
            r_skid_d0   <= '0;
            r_skid_d1   <= '0;
            r_skid_sel  <= 1'b0;
        end else if (flush_i) begin
            // Data registers keep stale contents; only valid matters after a squash.
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_main_d0   <= data0_i;
                        r_main_d1   <= data1_i;
                        r_main_sel  <= select_i;
                        r_state     <= BUSY;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_d0  <= data0_i;
                        r_main_d1  <= data1_i;
                        r_main_sel <= select_i;
                    end else if (w_in_fire) begin
                        r_skid_d0   <= data0_i;
                        r_skid_d1   <= data1_i;
                        r_skid_sel  <= select_i;
                        r_state     <= FULL;
                        r_in_ready  <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        r_main_d0  <= r_skid_d0;
                        r_main_d1  <= r_skid_d1;
                        r_main_sel <= r_skid_sel;
                        r_state    <= BUSY;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign data0_o     = r_main_d0;
    assign data1_o     = r_main_d1;
    assign select_o    = r_main_sel;

endmodule

// File: tb/tb_mux_operand_skid_reg.sv
// Randomized and directed bench for mux_operand_skid_reg, checked against
// a two-deep FIFO queue model of the stage.
module tb_mux_operand_skid_reg;

    localparam int SZ = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [SZ-1:0] data0_i;
    logic [SZ-1:0] data1_i;
    logic          select_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [SZ-1:0] data0_o;
    logic [SZ-1:0] data1_o;
    logic          select_o;

    int checks = 0;
    int errors = 0;

    logic [2*SZ:0] q[$];
    logic          r_prev_stall = 1'b0;
    logic [2*SZ:0] r_prev_bundle = '0;

    mux_operand_skid_reg #(.size(SZ)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data0_i     (data0_i),
        .data1_i     (data1_i),
        .select_i    (select_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data0_o     (data0_o),
        .data1_o     (data1_o),
        .select_o    (select_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [SZ-1:0] d0, input logic [SZ-1:0] d1,
                         input logic s, input logic rdy, input logic fl);
        in_valid_i  = v;
        data0_i     = d0;
        data1_i     = d1;
        select_i    = s;
        out_ready_i = rdy;
        flush_i     = fl;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        bit inf;
        bit outf;
        @(negedge clk_i);
        chk("out_valid", out_valid_o, q.size() > 0);
        chk("in_ready", in_ready_o, q.size() < 2);
        if (q.size() > 0) begin
            chk("data0", data0_o, q[0][2*SZ:SZ+1]);
            chk("data1", data1_o, q[0][SZ:1]);
            chk("select", select_o, q[0][0]);
        end
        if (r_prev_stall)
            chk("stall_stable", {data0_o, data1_o, select_o}, r_prev_bundle);
        inf  = in_valid_i && (q.size() < 2);
        outf = out_ready_i && (q.size() > 0);
        r_prev_stall  = (q.size() > 0) && !out_ready_i && !flush_i;
        r_prev_bundle = {data0_o, data1_o, select_o};
        @(posedge clk_i);
        if (flush_i) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back({data0_i, data1_i, select_i});
        end
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(0, '0, '0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_data", {data0_o, data1_o, select_o}, 0);
        rst_i = 1'b0;

        // single bundle
        drive(1, 32'h11, 32'h22, 1, 1, 0);
        step();
        drive(0, '0, '0, 0, 1, 0);
        chk("t1_valid", out_valid_o, 1);
        chk("t1_bundle", {data0_o, data1_o, select_o}, {32'h11, 32'h22, 1'b1});
        step();
        chk("t1_empty", out_valid_o, 0);

        // streaming
        for (int k = 0; k < 8; k++) begin
            drive(1, k, k + 100, k[0], 1, 0);
            step();
            chk("t2_ready", in_ready_o, 1);
            chk("t2_data0", data0_o, k);
        end
        drive(0, '0, '0, 0, 1, 0);
        step();

        // backpressure into skid
        drive(1, 5, 105, 0, 0, 0);
        step();
        drive(1, 6, 106, 1, 0, 0);
        step();
        chk("t3_full_ready", in_ready_o, 0);
        chk("t3_hold", data0_o, 5);
        drive(1, 7, 107, 1, 0, 0);
        step();
        chk("t3_c_hold", data0_o, 5);
        drive(1, 7, 107, 1, 1, 0);
        step();
        chk("t3_second", data0_o, 6);
        step();
        chk("t3_third", data0_o, 7);
        drive(0, '0, '0, 0, 1, 0);
        step();
        chk("t3_drained", out_valid_o, 0);

        // flush while full
        drive(1, 1, 101, 0, 0, 0);
        step();
        drive(1, 2, 102, 0, 0, 0);
        step();
        drive(1, 9, 109, 1, 0, 1);
        step();
        chk("t4_valid", out_valid_o, 0);
        chk("t4_ready", in_ready_o, 1);
        drive(0, '0, '0, 0, 1, 0);
        step();
        step();
        chk("t4_no_d", out_valid_o, 0);

        // async reset mid-operation
        drive(1, 32'hAA, 32'hBB, 1, 0, 0);
        step();
        drive(0, '0, '0, 0, 0, 0);
        chk("t5_busy", out_valid_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t5_valid", out_valid_o, 0);
        chk("t5_ready", in_ready_o, 1);
        chk("t5_data", {data0_o, data1_o, select_o}, 0);
        q.delete();
        r_prev_stall = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // random handshake
        for (int n = 0; n < 10000; n++) begin
            drive($urandom_range(0, 2) != 0, $urandom, $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
            step();
        end
        drive(0, '0, '0, 0, 1, 0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
